i2s_tx: RTL and testbench

Audio-path I2S transmitter. Accepts stereo 24-bit two's-complement sample pairs (e.g. FIR filter output) over a valid/ready handshake. Serializes each pair MSB-first onto a standard Philips I2S link toward the DAC, generating BCLK and LRCK as master from the system clock. It is the output-side counterpart of the sample receive path that feeds the filter chain.

---
 rtl/audio_pkg.sv | 20 ++
 rtl/i2s_bclk_gen.sv | 38 +++
 rtl/i2s_tx.sv | 104 ++++++++++
 tb/tb_i2s_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample geometry, the sample type and small
// helpers used by the serial audio blocks.
package audio_pkg;

  localparam int SAMPLE_W   = 24;
  localparam int I2S_SLOT_W = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides clk down to bclk and flags the clk edge on
// which bclk falls so the transmitter can update its outputs on that edge.
module i2s_bclk_gen
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic bclk,
  output logic fall_evt
);

  localparam int PW = cnt_width(BCLK_DIV);

  logic [PW-1:0] presc_reg;
  logic          bclk_reg;
  logic          term;

  assign term = (presc_reg == PW'(BCLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg <= '0;
      bclk_reg  <= 1'b0;
    end else if (term) begin
      presc_reg <= '0;
      bclk_reg  <= ~bclk_reg;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // Combinational so the transmitter's registers move on the same edge as bclk.
  assign fall_evt = term & bclk_reg;
  assign bclk     = bclk_reg;

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S master transmitter: one-deep sample-pair buffer behind a
// valid/ready handshake, serialized MSB-first with the standard one-bit delay.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int N        = SAMPLE_W,
  parameter int SLOT_W   = I2S_SLOT_W,
  parameter int BCLK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] left_in,
  input  logic [N-1:0] right_in,
  output logic         bclk,
  output logic         lrck,
  output logic         sdata,
  output logic         underrun
);

  localparam int FRAME = 2 * SLOT_W;
  localparam int CW    = cnt_width(FRAME);
  localparam int IW    = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic          fall_evt;
  logic [CW-1:0] bit_cnt_reg, bit_cnt_next;
  logic [N-1:0]  buf_l_reg, buf_r_reg;
  logic          buf_full_reg, buf_full_next;
  logic [N-1:0]  left_sh_reg, right_sh_reg;
  logic          in_ready_reg, lrck_reg, sdata_reg, underrun_reg;
  logic          frame_load, xfer, sdata_next;
  channel_e      lrck_next;

  i2s_bclk_gen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_bclk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .bclk    (bclk),
    .fall_evt(fall_evt)
  );

  always_comb begin
    bit_cnt_next = (bit_cnt_reg == LAST) ? '0 : bit_cnt_reg + 1'b1;
    frame_load   = fall_evt && (bit_cnt_next == '0);
    xfer         = in_valid && in_ready_reg;
    lrck_next    = (bit_cnt_next >= CW'(SLOT_W)) ? CH_RIGHT : CH_LEFT;

    // Data occupies slot positions 1..N; position 0 and the tail are padding.
    sdata_next = 1'b0;
    if (bit_cnt_next >= CW'(1) && bit_cnt_next <= CW'(N))
      sdata_next = left_sh_reg[IW'(N - int'(bit_cnt_next))];
    else if (bit_cnt_next >= CW'(SLOT_W + 1) && bit_cnt_next <= CW'(SLOT_W + N))
      sdata_next = right_sh_reg[IW'(N + SLOT_W - int'(bit_cnt_next))];

    // A transfer can only happen with the buffer empty, so it wins over a load.
    buf_full_next = buf_full_reg;
    if (xfer)
      buf_full_next = 1'b1;
    else if (frame_load)
      buf_full_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_reg  <= LAST;
      buf_l_reg    <= '0;
      buf_r_reg    <= '0;
      buf_full_reg <= 1'b0;
      in_ready_reg <= 1'b1;
      left_sh_reg  <= '0;
      right_sh_reg <= '0;
      lrck_reg     <= 1'b0;
      sdata_reg    <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      buf_full_reg <= buf_full_next;
      in_ready_reg <= !buf_full_next;
      underrun_reg <= frame_load && !buf_full_reg;
      if (xfer) begin
        buf_l_reg <= left_in;
        buf_r_reg <= right_in;
      end
      if (fall_evt) begin
        bit_cnt_reg <= bit_cnt_next;
        lrck_reg    <= lrck_next;
        sdata_reg   <= sdata_next;
      end
      // A frame with nothing buffered goes out as silence.
      if (frame_load) begin
        left_sh_reg  <= buf_full_reg ? buf_l_reg : '0;
        right_sh_reg <= buf_full_reg ? buf_r_reg : '0;
      end
    end
  end

  assign in_ready = in_ready_reg;
  assign lrck     = lrck_reg;
  assign sdata    = sdata_reg;
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: arithmetic timing model plus an I2S receiver
// that decodes the serial stream back into sample pairs.
module tb_i2s_tx;

  localparam int N  = 24;
  localparam int S  = 32;
  localparam int D  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        reset_n, in_valid, in_ready, bclk, lrck, sdata, underrun;
  logic [23:0] left_in, right_in;
  // BCLK_DIV=1 instance
  logic        rst1, valid1, ready1, bclk1, lrck1, sdata1, und1;
  logic [23:0] l1, r1;

  i2s_tx dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .left_in(left_in), .right_in(right_in), .bclk(bclk), .lrck(lrck),
    .sdata(sdata), .underrun(underrun)
  );

  i2s_tx #(.BCLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(rst1), .in_valid(valid1), .in_ready(ready1),
    .left_in(l1), .right_in(r1), .bclk(bclk1), .lrck(lrck1),
    .sdata(sdata1), .underrun(und1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (arithmetic on clk edge count) -------
  function automatic bit is_load(input int c, input int d);
    return (c >= 2*d) && (((c - 2*d) % (4*S*d)) == 0);
  endfunction

  // Slot position after edge c, -1 before the first bclk fall.
  function automatic int kval(input int c, input int d);
    int f;
    f = (c >= 2*d) ? (c - 2*d) / (2*d) + 1 : 0;
    return (f == 0) ? -1 : (f - 1) % (2*S);
  endfunction

  function automatic logic exp_bit(input int k, input logic [23:0] l, input logic [23:0] r);
    if (k >= 1 && k <= N) return l[N-k];
    if (k >= S+1 && k <= S+N) return r[N-(k-S)];
    return 1'b0;
  endfunction

  int          cyc = 0;
  bit          mbuf, m_old, mund;
  logic [23:0] mbl, mbr, cur_l, cur_r;
  logic [47:0] exp_frames[$];

  always @(posedge clk) begin
    if (!reset_n) begin
      cyc = 0; mbuf = 0; mund = 0; cur_l = '0; cur_r = '0;
      exp_frames.delete();
    end else begin
      cyc++;
      m_old = mbuf;
      mund  = 0;
      if (is_load(cyc, D)) begin
        if (m_old) begin cur_l = mbl; cur_r = mbr; mbuf = 0; end
        else begin cur_l = '0; cur_r = '0; mund = 1; end
        exp_frames.push_back({cur_l, cur_r});
      end
      if (in_valid && !m_old) begin
        mbl = left_in; mbr = right_in; mbuf = 1;
        $display("[TB] accept cyc=%0d L=%h R=%h", cyc, left_in, right_in);
      end
    end
  end

  // ---------------- per-cycle compare + I2S receiver -----------------------
  int          rx_pos = -2;
  bit          rx_prev_lrck, rx_prev_bclk;
  logic [23:0] rx_l, rx_r, first_l, first_r;
  bit          first_seen = 0;
  int          rx_frames = 0;
  logic [47:0] e;
  int          kk;

  always @(posedge clk) begin
    #3;
    if (!reset_n) begin
      chk("rst_bclk", bclk, 0);
      chk("rst_lrck", lrck, 0);
      chk("rst_sdata", sdata, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_underrun", underrun, 0);
      rx_pos = -2; rx_prev_bclk = 0; rx_prev_lrck = 0;
    end else begin
      kk = kval(cyc, D);
      chk("bclk", bclk, (cyc / D) % 2);
      chk("lrck", lrck, kk >= S);
      chk("sdata", sdata, exp_bit(kk, cur_l, cur_r));
      chk("in_ready", in_ready, !mbuf);
      chk("underrun", underrun, mund);
      if (rx_prev_bclk && !bclk && rx_pos == -2) rx_pos = -1;
      if (!rx_prev_bclk && bclk && rx_pos != -2) begin
        if (rx_pos == -1) rx_pos = 0;
        else if (lrck != rx_prev_lrck) begin chk("slot_len", rx_pos, S-1); rx_pos = 0; end
        else rx_pos++;
        if (rx_pos >= S) chk("slot_overrun", rx_pos, S-1);
        rx_prev_lrck = lrck;
        if (rx_pos >= 1 && rx_pos <= N) begin
          if (!lrck) rx_l = {rx_l[22:0], sdata};
          else       rx_r = {rx_r[22:0], sdata};
        end else begin
          chk("pad", sdata, 0);
        end
        if (lrck && rx_pos == N) begin
          rx_frames++;
          $display("[TB] frame %0d rx L=%h R=%h", rx_frames, rx_l, rx_r);
          if (!first_seen) begin first_l = rx_l; first_r = rx_r; first_seen = 1; end
          if (exp_frames.size() == 0) begin
            chk("rx_extra_frame", 1, 0);
          end else begin
            e = exp_frames.pop_front();
            chk("rx_left", rx_l, e[47:24]);
            chk("rx_right", rx_r, e[23:0]);
          end
        end
      end
      rx_prev_bclk = bclk;
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 5000) begin @(negedge clk); g++; end
    if (cyc < n) chk("wait_timeout", cyc, n);
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r, output int acc);
    int g = 0;
    in_valid = 1; left_in = l; right_in = r;
    while (!in_ready && g < 3000) begin @(negedge clk); g++; end
    if (!in_ready) begin
      chk("send_timeout", in_ready, 1);
      in_valid = 0; acc = -1;
      return;
    end
    acc = cyc + 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  // ---------------- main stimulus -----------------------------------------
  bit done1 = 0;
  int acc, gap;
  int g2;

  initial begin
    reset_n = 0; in_valid = 0; left_in = '0; right_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1; in_valid = 1; left_in = 24'hA5A5A5; right_in = 24'h123456;
    wait_cyc(1); in_valid = 0;
    wait_cyc(3);   chk("bclk_e3", bclk, 0);
    wait_cyc(4);   chk("bclk_e4", bclk, 1); chk("ready_e4", in_ready, 0);
    wait_cyc(8);   chk("bclk_e8", bclk, 0); chk("ready_e8", in_ready, 1); chk("und_e8", underrun, 0);
    wait_cyc(16);  chk("lmsb_e16", sdata, 1);
    wait_cyc(24);  chk("lbit22_e24", sdata, 0);
    wait_cyc(263); chk("lrck_e263", lrck, 0);
    wait_cyc(264); chk("lrck_e264", lrck, 1);
    wait_cyc(296); chk("rbit20_e296", sdata, 1);
    wait_cyc(520); chk("und_e520", underrun, 1); chk("lrck_e520", lrck, 0);
    chk("first_left", first_l, 24'hA5A5A5);
    chk("first_right", first_r, 24'h123456);
    wait_cyc(521); chk("und_e521", underrun, 0);

    // backpressure: P1 then P2 held back-to-back
    wait_cyc(600);
    send(24'($urandom), 24'($urandom), acc); chk("p1_accept_cyc", acc, 601);
    send(24'($urandom), 24'($urandom), acc); chk("p2_accept_cyc", acc, 1033);
    wait_cyc(1544); chk("und_e1544", underrun, 0);

    // transfer on the same edge as an empty-buffer frame load
    wait_cyc(2055);
    send(24'($urandom), 24'($urandom), acc); chk("coinc_accept_cyc", acc, 2056);
    chk("coinc_underrun", underrun, 1);

    for (int i = 0; i < 6; i++) begin
      gap = $urandom_range(0, 900);
      wait_cyc(cyc + gap);
      send(24'($urandom), 24'($urandom), acc);
    end

    // mid-frame reset with one pair on air and one buffered
    send(24'hFFFFFF, 24'($urandom), acc);
    send(24'($urandom), 24'($urandom), acc);
    g2 = 0;
    while (!(kval(cyc, D) == 10 && ((cyc / D) % 2) == 1) && g2 < 3000) begin
      @(negedge clk); g2++;
    end
    chk("pre_rst_bclk", bclk, 1);
    chk("pre_rst_sdata", sdata, 1);
    reset_n = 0;
    #1;
    chk("async_bclk", bclk, 0);
    chk("async_lrck", lrck, 0);
    chk("async_sdata", sdata, 0);
    chk("async_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    reset_n = 1;
    wait_cyc(8);   chk("post_rst_und_e8", underrun, 1);
    wait_cyc(600);

    g2 = 0;
    while (!done1 && g2 < 1000) begin @(negedge clk); g2++; end
    chk("dut1_done", done1, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- BCLK_DIV=1 extremes -----------------------------------
  logic [1:0]  q1[$];
  int          u1[$];
  logic [23:0] dl, dr;
  int          lr_bad, z_bad;
  bit          p1;

  initial begin
    rst1 = 0; valid1 = 0; l1 = '0; r1 = '0; p1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst1 = 1; valid1 = 1; l1 = 24'h800000; r1 = 24'h7FFFFF;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #3;
      if (c == 1) valid1 = 0;
      chk("bclk1", bclk1, c % 2);
      if (bclk1 && !p1) q1.push_back({lrck1, sdata1});
      p1 = bclk1;
      if (und1) u1.push_back(c);
    end
    chk("dut1_rises", q1.size() >= 130, 1);
    if (q1.size() >= 130) begin
      dl = '0; dr = '0; lr_bad = 0; z_bad = 0;
      for (int k = 1; k <= N; k++) dl = {dl[22:0], q1[k+1][0]};
      for (int k = S+1; k <= S+N; k++) dr = {dr[22:0], q1[k+1][0]};
      for (int k = 0; k < 2*S; k++) if (q1[k+1][1] != (k >= S)) lr_bad++;
      for (int k = 0; k < 2*S; k++) if (q1[2*S+k+1][0]) z_bad++;
      $display("[TB] dut1 frame rx L=%h R=%h", dl, dr);
      chk("dut1_left", dl, 24'h800000);
      chk("dut1_right", dr, 24'h7FFFFF);
      chk("dut1_lrck_bits_bad", lr_bad, 0);
      chk("dut1_zero_frame_bits_bad", z_bad, 0);
    end
    chk("dut1_underrun_count", u1.size(), 2);
    if (u1.size() >= 1) chk("dut1_underrun_edge", u1[0], 130);
    done1 = 1;
  end

endmodule
